ws2812_rx: RTL and testbench



---
 rtl/ws2812_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/ws2812_rx.sv | 158 +++++++++++++++
 tb/tb_ws2812_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - WS2812 receiver state encoding, shared timing constants and GRB layout
package ws2812_pkg;

   typedef enum logic [1:0] {
      S_SYNC,
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_e;

   // Nominal waveform at 20 MHz, also used by the transmitter side
   localparam int unsigned T0H     = 8;
   localparam int unsigned T1H     = 16;
   localparam int unsigned TBIT    = 25;
   localparam int unsigned T_LATCH = 1000;

   localparam int unsigned G_MSB = 23;
   localparam int unsigned G_LSB = 16;
   localparam int unsigned R_MSB = 15;
   localparam int unsigned R_LSB = 8;
   localparam int unsigned B_MSB = 7;
   localparam int unsigned B_LSB = 0;

   function automatic logic [23:0] grb_pack(input logic [7:0] g, input logic [7:0] r,
                                            input logic [7:0] b);
      logic [23:0] w;
      w               = '0;
      w[G_MSB:G_LSB]  = g;
      w[R_MSB:R_LSB]  = r;
      w[B_MSB:B_LSB]  = b;
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit double-flop synchronizer with synchronous active-high reset
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic q_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ receiver: recovers GRB pixel words and frame latch gaps
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int unsigned HIGH_MIN     = 4,
   parameter int unsigned ONE_MIN      = 12,
   parameter int unsigned HIGH_MAX     = 30,
   parameter int unsigned LATCH_CYCLES = T_LATCH,
   parameter int unsigned BITS         = 24
) (
   input  logic            CLK_IN,
   input  logic            RESET,
   input  logic            DIN,
   output logic [BITS-1:0] DATA,
   output logic            VALID,
   output logic            LATCH,
   output logic [15:0]     PIXEL_CNT,
   output logic            ERR
);

   localparam int CW = $clog2(LATCH_CYCLES + 1);
   localparam int BW = $clog2(BITS + 1);
   localparam logic [CW-1:0] C_HIGH_MIN = CW'(HIGH_MIN);
   localparam logic [CW-1:0] C_ONE_MIN  = CW'(ONE_MIN);
   localparam logic [CW-1:0] C_HIGH_MAX = CW'(HIGH_MAX);
   localparam logic [CW-1:0] C_LATCH    = CW'(LATCH_CYCLES);
   localparam logic [BW-1:0] C_LAST_BIT = BW'(BITS - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   bit_idx_q, bit_idx_d;
   logic [BITS-1:0] shift_q, shift_d;
   logic [BITS-1:0] data_q, data_d;
   logic [15:0]     pixel_cnt_q, pixel_cnt_d;
   logic            valid_q, valid_d;
   logic            latch_q, latch_d;
   logic            err_q, err_d;
   logic            din_prev_q, din_prev_d;

   logic            din_s;
   logic            rise, fall, bit_val;
   logic [BITS-1:0] shift_next;

   sync_2ff u_sync (
      .clk   (CLK_IN),
      .rst   (RESET),
      .d_in  (DIN),
      .q_out (din_s)
   );

   always_comb begin
      rise        = din_s & ~din_prev_q;
      fall        = ~din_s & din_prev_q;
      bit_val     = (cnt_q >= C_ONE_MIN);
      shift_next  = {shift_q[BITS-2:0], bit_val};

      state_d     = state_q;
      din_prev_d  = din_s;
      cnt_d       = (rise | fall) ? CW'(1) :
                    ((cnt_q == C_LATCH) ? cnt_q : cnt_q + CW'(1));
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      latch_d     = 1'b0;
      err_d       = 1'b0;
      // The latch cycle still shows the frame's count; it clears one cycle later
      pixel_cnt_d = latch_q ? 16'd0 : pixel_cnt_q;

      case (state_q)
         S_SYNC: begin
            bit_idx_d = '0;
            if (din_s) begin
               cnt_d = '0;
            end else if (cnt_q == C_LATCH) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (rise) begin
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (fall) begin
               if (cnt_q < C_HIGH_MIN) begin
                  err_d     = 1'b1;
                  bit_idx_d = '0;
                  state_d   = S_SYNC;
               end else begin
                  shift_d = shift_next;
                  state_d = S_LOW;
                  if (bit_idx_q == C_LAST_BIT) begin
                     data_d      = shift_next;
                     valid_d     = 1'b1;
                     bit_idx_d   = '0;
                     pixel_cnt_d = (pixel_cnt_q == 16'hFFFF) ? pixel_cnt_q
                                                             : pixel_cnt_q + 16'd1;
                  end else begin
                     bit_idx_d = bit_idx_q + BW'(1);
                  end
               end
            end else if (cnt_q >= C_HIGH_MAX) begin
               // Still high after HIGH_MAX cycles: flag now rather than waiting for the fall
               err_d     = 1'b1;
               bit_idx_d = '0;
               state_d   = S_SYNC;
            end
         end
         S_LOW: begin
            if (rise) begin
               state_d = S_HIGH;
            end else if (cnt_d == C_LATCH) begin
               latch_d   = 1'b1;
               err_d     = (bit_idx_q != '0);
               bit_idx_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_SYNC;
         end
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (RESET) begin
         state_q     <= S_SYNC;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         pixel_cnt_q <= '0;
         valid_q     <= 1'b0;
         latch_q     <= 1'b0;
         err_q       <= 1'b0;
         din_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         pixel_cnt_q <= pixel_cnt_d;
         valid_q     <= valid_d;
         latch_q     <= latch_d;
         err_q       <= err_d;
         din_prev_q  <= din_prev_d;
      end
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign LATCH     = latch_q;
   assign PIXEL_CNT = pixel_cnt_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx with a pulse-level reference model
module tb_ws2812_rx;
   import ws2812_pkg::*;

   logic        CLK_IN = 1'b0;
   logic        RESET  = 1'b1;
   logic        DIN    = 1'b0;
   logic [23:0] DATA;
   logic        VALID, LATCH, ERR;
   logic [15:0] PIXEL_CNT;

   int checks = 0;
   int errors = 0;

   ws2812_rx dut (
      .CLK_IN    (CLK_IN),
      .RESET     (RESET),
      .DIN       (DIN),
      .DATA      (DATA),
      .VALID     (VALID),
      .LATCH     (LATCH),
      .PIXEL_CNT (PIXEL_CNT),
      .ERR       (ERR)
   );

   always #25 CLK_IN = ~CLK_IN;

   int cyc = 0;
   always @(posedge CLK_IN) cyc <= cyc + 1;

   // Observed events
   logic [23:0] act_words[$];
   logic [15:0] act_vpix[$];
   logic [15:0] act_lpix[$];
   logic [15:0] act_post[$];
   logic        act_lerr[$];
   int          act_err = 0;
   int          act_both = 0;
   logic        post_latch = 1'b0;
   int          last_valid_cyc = 0;
   int          last_latch_cyc = 0;
   int          fall_cyc = 0;

   always @(negedge CLK_IN) begin
      if (post_latch) act_post.push_back(PIXEL_CNT);
      post_latch = LATCH;
      if (VALID) begin
         act_words.push_back(DATA);
         act_vpix.push_back(PIXEL_CNT);
         last_valid_cyc = cyc;
      end
      if (LATCH) begin
         act_lpix.push_back(PIXEL_CNT);
         act_lerr.push_back(ERR);
         last_latch_cyc = cyc;
      end
      if (ERR) act_err = act_err + 1;
      if (VALID && LATCH) act_both = act_both + 1;
   end

   // Reference model: works on whole pulses (high width, following low width)
   logic [23:0] exp_words[$];
   logic [15:0] exp_vpix[$];
   logic [15:0] exp_lpix[$];
   logic        exp_lerr[$];
   int          exp_err = 0;
   logic        m_synced = 1'b0;
   logic        m_frame = 1'b0;
   int          m_nbits = 0;
   logic [23:0] m_acc = '0;
   logic [23:0] m_last = '0;
   logic [15:0] m_pix = '0;

   task automatic model_reset();
      m_synced = 1'b0; m_frame = 1'b0; m_nbits = 0; m_acc = '0; m_last = '0; m_pix = '0;
   endtask

   task automatic model_latch();
      exp_lpix.push_back(m_pix);
      exp_lerr.push_back(m_nbits != 0);
      if (m_nbits != 0) exp_err++;
      m_pix = '0; m_nbits = 0; m_frame = 1'b0;
   endtask

   task automatic model_pulse(input int hi, input int lo);
      if (m_synced) begin
         if (hi < 4 || hi > 30) begin
            exp_err++;
            m_nbits = 0; m_frame = 1'b0; m_synced = 1'b0;
         end else begin
            m_acc = {m_acc[22:0], (hi >= 12)};
            m_nbits++;
            m_frame = 1'b1;
            if (m_nbits == 24) begin
               if (m_pix != 16'hFFFF) m_pix++;
               exp_words.push_back(m_acc);
               exp_vpix.push_back(m_pix);
               m_last = m_acc;
               m_nbits = 0;
            end
            if (lo >= 1000) model_latch();
         end
      end
      if (!m_synced && lo >= 1000) m_synced = 1'b1;
   endtask

   task automatic clear();
      act_words.delete(); act_vpix.delete(); act_lpix.delete(); act_post.delete();
      act_lerr.delete(); act_err = 0; act_both = 0;
      exp_words.delete(); exp_vpix.delete(); exp_lpix.delete(); exp_lerr.delete();
      exp_err = 0;
   endtask

   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK_IN);
         #1;
         if (DIN === 1'b1 && v == 1'b0) fall_cyc = cyc;
         DIN = v;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      model_pulse(hi, lo);
      drive(1'b1, hi);
      drive(1'b0, lo);
   endtask

   task automatic low_only(input int n);
      if (m_synced && m_frame && n >= 1000) model_latch();
      if (!m_synced && n >= 1000) m_synced = 1'b1;
      drive(1'b0, n);
   endtask

   task automatic send_word(input logic [23:0] w, input int last_lo);
      int hi;
      for (int i = 23; i >= 0; i--) begin
         hi = w[i] ? int'(T1H) : int'(T0H);
         pulse(hi, (i == 0) ? last_lo : int'(TBIT) - hi);
      end
   endtask

   task automatic send_word_rand(input logic [23:0] w, input int last_lo);
      int hi;
      for (int i = 23; i >= 0; i--) begin
         hi = w[i] ? int'($urandom_range(30, 12)) : int'($urandom_range(11, 4));
         pulse(hi, (i == 0) ? last_lo : int'($urandom_range(60, 1)));
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      DIN = 1'b0;
      repeat (3) @(posedge CLK_IN);
      #1 RESET = 1'b0;
      model_reset();
      @(negedge CLK_IN);
      checks++; if (DATA !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", DATA); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID); end
      checks++; if (LATCH !== 1'b0) begin errors++; $display("FAIL reset_latch got %b want 0", LATCH); end
      checks++; if (PIXEL_CNT !== 16'h0) begin errors++; $display("FAIL reset_pixcnt got %0d want 0", PIXEL_CNT); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
   endtask

   task automatic test_sync_gate();
      clear();
      low_only(1100);
      checks++; if (act_lpix.size() != 0) begin errors++; $display("FAIL sync_no_latch got %0d want 0", act_lpix.size()); end
      send_word(24'hFF0080, 1100);
      checks++; if (act_words.size() != 1) begin errors++; $display("FAIL sync_valid_count got %0d want 1", act_words.size()); end
      if (act_words.size() > 0) begin
         checks++; if (act_words[0] !== 24'hFF0080) begin errors++; $display("FAIL sync_data got %h want ff0080", act_words[0]); end
         checks++; if (act_vpix[0] !== 16'd1) begin errors++; $display("FAIL sync_pixcnt got %0d want 1", act_vpix[0]); end
      end
      checks++; if (last_valid_cyc - fall_cyc != 3) begin errors++; $display("FAIL valid_latency got %0d want 3", last_valid_cyc - fall_cyc); end
      checks++; if (act_err != 0) begin errors++; $display("FAIL sync_err got %0d want 0", act_err); end
   endtask

   task automatic test_frame();
      clear();
      send_word(24'h123456, 20);
      send_word(24'hABCDEF, 20);
      send_word(24'h000001, 1100);
      checks++; if (act_words.size() != exp_words.size()) begin errors++; $display("FAIL frame_valid_count got %0d want %0d", act_words.size(), exp_words.size()); end
      for (int i = 0; i < exp_words.size() && i < act_words.size(); i++) begin
         checks++; if (act_words[i] !== exp_words[i]) begin errors++; $display("FAIL frame_data[%0d] got %h want %h", i, act_words[i], exp_words[i]); end
         checks++; if (act_vpix[i] !== exp_vpix[i]) begin errors++; $display("FAIL frame_pixcnt[%0d] got %0d want %0d", i, act_vpix[i], exp_vpix[i]); end
      end
      checks++; if (act_lpix.size() != 1) begin errors++; $display("FAIL frame_latch_count got %0d want 1", act_lpix.size()); end
      if (act_lpix.size() > 0) begin
         checks++; if (act_lpix[0] !== 16'd3) begin errors++; $display("FAIL frame_latch_pixcnt got %0d want 3", act_lpix[0]); end
      end
      if (act_post.size() > 0) begin
         checks++; if (act_post[0] !== 16'd0) begin errors++; $display("FAIL frame_post_latch_pixcnt got %0d want 0", act_post[0]); end
      end
      checks++; if (last_latch_cyc - fall_cyc != 1002) begin errors++; $display("FAIL latch_latency got %0d want 1002", last_latch_cyc - fall_cyc); end
      checks++; if (act_err != 0 || act_both != 0) begin errors++; $display("FAIL frame_err got %0d/%0d want 0/0", act_err, act_both); end
   endtask

   task automatic test_thresholds();
      int hi;
      clear();
      for (int i = 0; i < 24; i++) begin
         hi = (i == 0) ? 4 : (i == 23) ? 30 : ((i % 2) != 0) ? 12 : 11;
         pulse(hi, (i == 23) ? 1100 : 10);
      end
      checks++; if (act_words.size() != 1 || exp_words.size() != 1) begin errors++; $display("FAIL thr_valid_count got %0d want 1", act_words.size()); end
      else begin
         checks++; if (act_words[0] !== exp_words[0]) begin errors++; $display("FAIL thr_data got %h want %h", act_words[0], exp_words[0]); end
      end
      pulse(3, 20);
      checks++; if (act_err != exp_err) begin errors++; $display("FAIL thr_short_err got %0d want %0d", act_err, exp_err); end
      send_word(24'hA5A5A5, 20);
      low_only(1100);
      checks++; if (act_words.size() != exp_words.size()) begin errors++; $display("FAIL thr_sync_ignore got %0d want %0d", act_words.size(), exp_words.size()); end
      drive(1'b1, 36);
      checks++; if (act_err != exp_err + 1) begin errors++; $display("FAIL thr_long_err_while_high got %0d want %0d", act_err, exp_err + 1); end
      drive(1'b0, 1100);
      model_pulse(36, 1100);
      send_word(24'h5A0FF0, 1100);
      checks++; if (act_words.size() != exp_words.size() || act_words[act_words.size()-1] !== 24'h5A0FF0) begin errors++; $display("FAIL thr_recover got %0d words want %0d", act_words.size(), exp_words.size()); end
      checks++; if (act_err != exp_err || act_lpix.size() != exp_lpix.size()) begin errors++; $display("FAIL thr_err_total got %0d want %0d", act_err, exp_err); end
   endtask

   task automatic test_partial();
      logic [23:0] w;
      logic [23:0] prev;
      clear();
      prev = m_last;
      w = 24'($urandom);
      for (int i = 23; i >= 14; i--) pulse(w[i] ? 16 : 8, (i == 14) ? 1100 : 17);
      checks++; if (act_lpix.size() != 1 || act_lerr.size() != 1) begin errors++; $display("FAIL part_latch_count got %0d want 1", act_lpix.size()); end
      else begin
         checks++; if (act_lerr[0] !== 1'b1) begin errors++; $display("FAIL part_err_with_latch got %b want 1", act_lerr[0]); end
      end
      checks++; if (act_err != exp_err) begin errors++; $display("FAIL part_err_count got %0d want %0d", act_err, exp_err); end
      checks++; if (act_words.size() != 0) begin errors++; $display("FAIL part_valid got %0d want 0", act_words.size()); end
      checks++; if (DATA !== prev) begin errors++; $display("FAIL part_data_kept got %h want %h", DATA, prev); end
   endtask

   task automatic test_mid_reset();
      logic [23:0] w;
      clear();
      w = 24'($urandom);
      for (int i = 23; i >= 12; i--) pulse(w[i] ? 16 : 8, (i == 12) ? 1 : 17);
      @(posedge CLK_IN);
      #1 RESET = 1'b1;
      @(posedge CLK_IN);
      #1 RESET = 1'b0;
      model_reset();
      @(negedge CLK_IN);
      checks++; if ({DATA, VALID, LATCH, PIXEL_CNT, ERR} !== '0) begin errors++; $display("FAIL midrst_outputs got %h/%b/%b/%0d/%b want 0", DATA, VALID, LATCH, PIXEL_CNT, ERR); end
      checks++; if (act_err != 0) begin errors++; $display("FAIL midrst_err got %0d want 0", act_err); end
      low_only(1100);
      w = 24'($urandom);
      send_word(w, 1100);
      checks++; if (act_words.size() != 1) begin errors++; $display("FAIL midrst_valid_count got %0d want 1", act_words.size()); end
      else begin
         checks++; if (act_words[0] !== w) begin errors++; $display("FAIL midrst_data got %h want %h", act_words[0], w); end
      end
   endtask

   task automatic test_loopback();
      logic [23:0] fb[4];
      clear();
      for (int k = 0; k < 4; k++) fb[k] = grb_pack(8'($urandom), 8'($urandom), 8'($urandom));
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 4; k++)
            send_word_rand(fb[k], (k == 3) ? 1100 : int'($urandom_range(60, 1)));
      checks++; if (act_words.size() != 8) begin errors++; $display("FAIL loop_word_count got %0d want 8", act_words.size()); end
      for (int i = 0; i < 8 && i < act_words.size(); i++) begin
         checks++; if (act_words[i] !== fb[i % 4]) begin errors++; $display("FAIL loop_data[%0d] got %h want %h", i, act_words[i], fb[i % 4]); end
      end
      checks++; if (act_lpix.size() != 2) begin errors++; $display("FAIL loop_latch_count got %0d want 2", act_lpix.size()); end
      for (int i = 0; i < act_lpix.size(); i++) begin
         checks++; if (act_lpix[i] !== 16'd4) begin errors++; $display("FAIL loop_latch_pixcnt[%0d] got %0d want 4", i, act_lpix[i]); end
      end
   endtask

   task automatic test_random();
      int sel;
      int hi;
      clear();
      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(19, 0));
         hi = (sel == 0) ? int'($urandom_range(3, 1)) :
              (sel == 1) ? int'($urandom_range(40, 31)) : int'($urandom_range(30, 4));
         pulse(hi, int'($urandom_range(60, 1)));
      end
      low_only(1100);
      checks++; if (act_words.size() != exp_words.size()) begin errors++; $display("FAIL rand_valid_count got %0d want %0d", act_words.size(), exp_words.size()); end
      for (int i = 0; i < exp_words.size() && i < act_words.size(); i++) begin
         checks++; if (act_words[i] !== exp_words[i] || act_vpix[i] !== exp_vpix[i]) begin errors++; $display("FAIL rand_word[%0d] got %h/%0d want %h/%0d", i, act_words[i], act_vpix[i], exp_words[i], exp_vpix[i]); end
      end
      checks++; if (act_err != exp_err) begin errors++; $display("FAIL rand_err_count got %0d want %0d", act_err, exp_err); end
      checks++; if (act_lpix.size() != exp_lpix.size()) begin errors++; $display("FAIL rand_latch_count got %0d want %0d", act_lpix.size(), exp_lpix.size()); end
      for (int i = 0; i < exp_lpix.size() && i < act_lpix.size(); i++) begin
         checks++; if (act_lpix[i] !== exp_lpix[i] || act_lerr[i] !== exp_lerr[i]) begin errors++; $display("FAIL rand_latch[%0d] got %0d/%b want %0d/%b", i, act_lpix[i], act_lerr[i], exp_lpix[i], exp_lerr[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_sync_gate();
      test_frame();
      test_thresholds();
      test_partial();
      test_mid_reset();
      test_loopback();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
